// File: rtl/rr_interval_scheduler.sv
// RR interval scheduler: timestamps R-peak edges and queues sample-count intervals.
// A shared restoring divider converts each interval to Q4.11 seconds.
module rr_interval_scheduler #(
    parameter int FS         = 360,
    parameter int CNT_W      = 16,
    parameter int FRAC_BITS  = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic        peak_detected,
    input  logic        rr_ready,
    output logic [15:0] rr_interval,
    output logic        rr_valid,
    output logic        rr_sat,
    output logic        overflow,
    output logic        busy
);

    localparam int QW     = CNT_W + FRAC_BITS;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int K_W    = $clog2(QW);
    localparam logic [CNT_W:0] FS_W = (CNT_W + 1)'(FS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [CNT_W-1:0]  pos;
    logic [CNT_W-1:0]  last_pos;
    logic              have_last;
    logic              peak_prev;
    logic              edge_det;
    logic [CNT_W-1:0]  interval;

    logic [CNT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [1:0]        state;
    logic [QW-1:0]     num;
    logic [QW-1:0]     quo;
    logic [CNT_W:0]    rem;
    logic [K_W-1:0]    k;
    logic [CNT_W:0]    rem_sh;
    logic [CNT_W:0]    rem_nx;
    logic              q_bit;
    logic [QW-1:0]     quo_nx;
    logic              sat;

    // Interval uses pos before any same-cycle increment; modular subtraction handles wrap.
    assign edge_det   = peak_detected & ~peak_prev;
    assign interval   = pos - last_pos;
    assign fifo_full  = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = edge_det & have_last & ~fifo_full;
    assign pop        = (state == S_IDLE) & ~fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos       <= '0;
            last_pos  <= '0;
            have_last <= 1'b0;
            peak_prev <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            peak_prev <= peak_detected;
            if (sample_en)
                pos <= pos + 1'b1;
            if (edge_det) begin
                last_pos  <= pos;
                have_last <= 1'b1;
                if (have_last && fifo_full)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= interval;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Restoring step: rem stays below FS, so its top bit only guards the compare.
    assign rem_sh = {rem[CNT_W-1:0], num[QW-1]};
    assign q_bit  = rem[CNT_W] | (rem_sh >= FS_W);
    assign rem_nx = q_bit ? (rem_sh - FS_W) : rem_sh;
    assign quo_nx = {quo[QW-2:0], q_bit};
    assign sat    = |quo_nx[QW-1:15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            num         <= '0;
            quo         <= '0;
            rem         <= '0;
            k           <= '0;
            rr_interval <= '0;
            rr_sat      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        num   <= {fifo_mem[rd_ptr], {FRAC_BITS{1'b0}}};
                        rem   <= '0;
                        quo   <= '0;
                        k     <= K_W'(QW - 1);
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    num <= num << 1;
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (k == '0) begin
                        rr_interval <= sat ? 16'h7FFF : {1'b0, quo_nx[14:0]};
                        rr_sat      <= sat;
                        state       <= S_OUT;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                S_OUT: begin
                    if (rr_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake: rr_valid holds with rr_interval/rr_sat stable until a cycle with
    // rr_valid & rr_ready; the transfer happens on that edge and rr_valid drops next cycle.
    assign rr_valid = (state == S_OUT);
    assign busy     = (state != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_rr_interval_scheduler.sv
// Directed bench for rr_interval_scheduler: vector table of intervals plus
// hand-written sequences for latency, wrap, backpressure/overflow and reset.
module tb_rr_interval_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic        peak_detected = 1'b0;
    logic        rr_ready = 1'b0;
    logic [15:0] rr_interval;
    logic        rr_valid;
    logic        rr_sat;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int tb_pos = 0;

    typedef struct {
        int          samples;
        logic [15:0] exp_rr;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[9];
    int          bp_samples[6];
    logic [15:0] bp_exp[5];

    rr_interval_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .sample_en     (sample_en),
        .peak_detected (peak_detected),
        .rr_ready      (rr_ready),
        .rr_interval   (rr_interval),
        .rr_valid      (rr_valid),
        .rr_sat        (rr_sat),
        .overflow      (overflow),
        .busy          (busy)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tb_pos = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sample_en = 1'b1;
            tick();
        end
        sample_en = 1'b0;
        tb_pos = (tb_pos + n) % 65536;
    endtask

    task automatic pulse();
        peak_detected = 1'b1;
        tick();
        peak_detected = 1'b0;
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!rr_valid && n < 200) begin
            tick();
            n++;
        end
        check({name, "_valid"}, rr_valid, 1'b1);
    endtask

    task automatic expect_result(input string name, input logic [15:0] er, input logic es);
        wait_valid(name);
        check({name, "_rr"}, rr_interval, er);
        check({name, "_sat"}, rr_sat, es);
        rr_ready = 1'b1;
        tick();
        rr_ready = 1'b0;
        check({name, "_drop"}, rr_valid, 1'b0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        repeat (cycles) tick();
        check(name, rr_valid, 1'b0);
    endtask

    initial begin
        int n;

        vecs[0] = '{360,  16'h0800, 1'b0};
        vecs[1] = '{288,  16'h0666, 1'b0};
        vecs[2] = '{540,  16'h0C00, 1'b0};
        vecs[3] = '{0,    16'h0000, 1'b0};
        vecs[4] = '{1,    16'h0005, 1'b0};
        vecs[5] = '{720,  16'h1000, 1'b0};
        vecs[6] = '{5759, 16'h7FFA, 1'b0};
        vecs[7] = '{5760, 16'h7FFF, 1'b1};
        vecs[8] = '{6000, 16'h7FFF, 1'b1};

        bp_samples = '{360, 720, 540, 288, 1, 66};
        bp_exp     = '{16'h0800, 16'h1000, 16'h0C00, 16'h0666, 16'h0005};

        tick();
        tick();
        check("rst_valid", rr_valid, 1'b0);
        check("rst_rr", rr_interval, 16'h0000);
        check("rst_sat", rr_sat, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        tb_pos = 0;

        // first peak at sample 100 never yields a result
        step(100);
        pulse();
        expect_quiet("first_peak_quiet", 40);
        check("first_peak_busy", busy, 1'b0);

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].samples);
            if (i == 0) begin
                peak_detected = 1'b1;
                tick();
                peak_detected = 1'b0;
                n = 1;
                while (!rr_valid && n < 200) begin
                    tick();
                    n++;
                end
                check("latency", n, 29);
                check("vec0_rr", rr_interval, vecs[0].exp_rr);
                check("vec0_sat", rr_sat, vecs[0].exp_sat);
                rr_ready = 1'b1;
                tick();
                rr_ready = 1'b0;
                check("vec0_drop", rr_valid, 1'b0);
            end else begin
                pulse();
                expect_result($sformatf("vec%0d", i), vecs[i].exp_rr, vecs[i].exp_sat);
            end
        end

        // pos wrap: last peak at 65530, next at 60 after wrap
        step(65530 - tb_pos);
        pulse();
        expect_result("pre_wrap", 16'h7FFF, 1'b1);
        step(66);
        check("wrap_pos", tb_pos, 60);
        pulse();
        expect_result("wrap", 16'h0177, 1'b0);
        check("no_overflow_yet", overflow, 1'b0);

        // backpressure: 1 in OUT + 4 queued, 6th dropped
        do_reset();
        step(10);
        pulse();
        for (int i = 0; i < 6; i++) begin
            step(bp_samples[i]);
            if (i == 5)
                check("bp_overflow_before", overflow, 1'b0);
            pulse();
        end
        check("bp_overflow_set", overflow, 1'b1);
        check("bp_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++)
            expect_result($sformatf("bp%0d", i), bp_exp[i], 1'b0);
        expect_quiet("bp_sixth_dropped", 60);
        check("bp_overflow_sticky", overflow, 1'b1);
        check("bp_idle", busy, 1'b0);

        // reset asserted mid-division
        step(360);
        peak_detected = 1'b1;
        tick();
        peak_detected = 1'b0;
        repeat (10) tick();
        check("div_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_div_valid", rr_valid, 1'b0);
        check("rst_div_busy", busy, 1'b0);
        check("rst_div_overflow", overflow, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tb_pos = 0;
        step(50);
        pulse();
        expect_quiet("rst_div_first_quiet", 40);
        step(540);
        pulse();
        expect_result("after_rst_div", 16'h0C00, 1'b0);

        // reset asserted while a result is held in OUT
        step(288);
        pulse();
        wait_valid("pre_rst_out");
        rst = 1'b1;
        #1;
        check("rst_out_valid", rr_valid, 1'b0);
        check("rst_out_rr", rr_interval, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        tb_pos = 0;
        step(20);
        pulse();
        expect_quiet("rst_out_first_quiet", 40);
        step(720);
        pulse();
        expect_result("after_rst_out", 16'h1000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
